// File: rtl/joystick_pkg.sv
// Shared definitions for the serial joystick reader: FSM states, the
// raw-bit to button-bit map and parameter legality helpers.
package joystick_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    // BIT_MAP[i] is the raw bit k that drives button bit i of a port.
    localparam logic [7:0][2:0] BIT_MAP = {3'd7, 3'd6, 3'd5, 3'd4,
                                           3'd0, 3'd1, 3'd2, 3'd3};

    function automatic bit ports_ok(input int unsigned ports);
        return (ports >= 1) && (ports <= 4);
    endfunction

    function automatic bit bits_ok(input int unsigned bits);
        return (bits >= 6) && (bits <= 8);
    endfunction

    function automatic bit div_ok(input int unsigned div);
        return div >= 2;
    endfunction

endpackage

// File: rtl/joystick_ce_div.sv
// Shift-tick divider: counts 0..DIV-1 and flags the last count as ce.
module ce_div #(
    parameter int unsigned DIV = 50
) (
    input  logic clock,
    input  logic reset,
    output logic ce
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign ce = (cnt_q == CW'(DIV - 1));

    // Next count: wrap to zero on the tick cycle.
    always_comb begin
        cnt_d = ce ? '0 : cnt_q + CW'(1);
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/joystick_serial.sv
// Daisy-chained serial joystick reader: load strobe, divided shift clock,
// PORTS x BITS raw bits mapped to per-port active-high 8-bit button words.
// Optional debounce when JOYSTICK_DEBOUNCE_EN is defined.
module joystick_serial
    import joystick_pkg::*;
#(
    parameter int unsigned PORTS = 2,
    parameter int unsigned BITS  = 8,
    parameter int unsigned DIV   = 50
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    output logic               joyCk,
    output logic               joyLd,
    output logic               joyS,
    input  logic               joyQ,
    output logic [PORTS*8-1:0] joy,
    output logic               valid,
    output logic               changed
);

    localparam int unsigned TOTAL = PORTS * BITS;
    localparam int unsigned NW    = $clog2(TOTAL + 1);
    localparam int unsigned JW    = PORTS * 8;

    if (!ports_ok(PORTS)) begin : g_bad_ports
        $error("joystick_serial: PORTS must be 1..4");
    end
    if (!bits_ok(BITS)) begin : g_bad_bits
        $error("joystick_serial: BITS must be 6..8");
    end
    if (!div_ok(DIV)) begin : g_bad_div
        $error("joystick_serial: DIV must be >= 2");
    end

    logic            ce;
    state_t          state_q, state_d;
    logic [NW-1:0]   n_q, n_d;
    logic            ck_q, ck_d;
    logic [TOTAL-1:0] raw_q, raw_d;
    logic [JW-1:0]   joy_q, joy_d;
    logic            valid_q, valid_d;
    logic            changed_q, changed_d;
    logic [JW-1:0]   mapped;
`ifdef JOYSTICK_DEBOUNCE_EN
    logic [JW-1:0]   hist_q, hist_d;
`endif

    ce_div #(.DIV(DIV)) u_ce_div (
        .clock (clock),
        .reset (reset),
        .ce    (ce)
    );

    // Raw bits are stored as received (active low); invert while mapping.
    for (genvar p = 0; p < PORTS; p++) begin : g_port
        for (genvar i = 0; i < 8; i++) begin : g_bit
            localparam int unsigned K = int'(BIT_MAP[i]);
            if (K < BITS) begin : g_used
                assign mapped[8*p+i] = ~raw_q[p*BITS+K];
            end else begin : g_zero
                assign mapped[8*p+i] = 1'b0;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            n_q       <= '0;
            ck_q      <= 1'b0;
            raw_q     <= '1;
            joy_q     <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
`ifdef JOYSTICK_DEBOUNCE_EN
            hist_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            ck_q      <= ck_d;
            raw_q     <= raw_d;
            joy_q     <= joy_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
`ifdef JOYSTICK_DEBOUNCE_EN
            hist_q    <= hist_d;
`endif
        end
    end

    // Frame sequencer: advances one step per ce tick.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        ck_d      = ck_q;
        raw_d     = raw_q;
        joy_d     = joy_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
`ifdef JOYSTICK_DEBOUNCE_EN
        hist_d    = hist_q;
`endif
        if (ce) begin
            unique case (state_q)
                IDLE: begin
                    if (enable) state_d = LOAD;
                end
                LOAD: begin
                    state_d = SHIFT;
                    n_d     = '0;
                    ck_d    = 1'b0;
                end
                SHIFT: begin
                    if (!ck_q) begin
                        ck_d = 1'b1;
                    end else begin
                        // Shifting in from the top leaves bit n at raw[n] once all bits are in.
                        raw_d = {joyQ, raw_q[TOTAL-1:1]};
                        ck_d  = 1'b0;
                        if (n_q == NW'(TOTAL - 1)) begin
                            n_d     = '0;
                            state_d = DONE;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end
                end
                DONE: begin
`ifdef JOYSTICK_DEBOUNCE_EN
                    joy_d  = (mapped == hist_q) ? mapped : joy_q;
                    hist_d = mapped;
`else
                    joy_d  = mapped;
`endif
                    valid_d   = 1'b1;
                    changed_d = (joy_d != joy_q);
                    raw_d     = '1;
                    state_d   = enable ? LOAD : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign joyCk   = ck_q;
    assign joyLd   = (state_q != LOAD);
    assign joyS    = 1'b1;
    assign joy     = joy_q;
    assign valid   = valid_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_joystick_serial.sv
// Self-checking bench for joystick_serial: adaptor model, frame-timing and
// button-mapping model checked every cycle, plus literal frame expectations.
module tb_joystick_serial;

    localparam int DIV   = 50;
    localparam int FRAME = 1700;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        joyQ = 1'b1;
    logic        joyCk, joyLd, joyS, valid, changed;
    logic [15:0] joy;

    logic        en3 = 1'b1;
    logic        joyQ3 = 1'b1;
    logic        joyCk3, joyLd3, joyS3, valid3, changed3;
    logic [23:0] joy3;

    logic [15:0] pat = 16'hFFFF;
    localparam logic [17:0] PAT3 = 18'h3EFFF;

    int checks = 0;
    int errors = 0;
    int nld, nrise;

    always #5 clock = ~clock;

    joystick_serial #(.PORTS(2), .BITS(8), .DIV(DIV)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .joyCk(joyCk), .joyLd(joyLd), .joyS(joyS), .joyQ(joyQ),
        .joy(joy), .valid(valid), .changed(changed)
    );

    joystick_serial #(.PORTS(3), .BITS(6), .DIV(4)) dut3 (
        .clock(clock), .reset(reset), .enable(en3),
        .joyCk(joyCk3), .joyLd(joyLd3), .joyS(joyS3), .joyQ(joyQ3),
        .joy(joy3), .valid(valid3), .changed(changed3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Button word from an active-low two-port raw pattern, by the k->i table.
    function automatic logic [15:0] map2(input logic [15:0] al);
        int src [8];
        logic [15:0] r;
        src = '{3, 2, 1, 0, 4, 5, 6, 7};
        r = '0;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 8; i++)
                r[8*p+i] = ~al[8*p+src[i]];
        return r;
    endfunction

    // Timing/mapping model, per-cycle compare, then the adaptor model.
    initial begin
        int t, nxt, off, idx;
        bit idle, ev, ec, pck, exp_ld, exp_ck;
        logic [15:0] jexp, hist, m, nj, lat;
        t = 0; nxt = 0; idx = 0; idle = 1'b1; pck = 1'b0;
        jexp = '0; hist = '0; lat = 16'hFFFF; nj = '0; m = '0;
        forever begin
            @(negedge clock);
            ev = 1'b0;
            ec = 1'b0;
            if (reset) begin
                t = 0; idle = 1'b1; jexp = '0; hist = '0;
            end else begin
                t++;
                if (!idle && t == nxt) begin
                    m = map2(lat);
`ifdef JOYSTICK_DEBOUNCE_EN
                    nj = (m == hist) ? m : jexp;
                    hist = m;
`else
                    nj = m;
`endif
                    ec = (nj != jexp);
                    jexp = nj;
                    ev = 1'b1;
                    if (enable) nxt = t + FRAME;
                    else idle = 1'b1;
                end else if (idle && (t % DIV) == 0 && enable) begin
                    idle = 1'b0;
                    nxt = t + FRAME;
                end
            end
            off = t - (nxt - FRAME);
            exp_ld = !(!idle && off >= 0 && off < DIV);
            exp_ck = !idle && off >= 2*DIV && off < FRAME && ((off - 2*DIV) % (2*DIV)) < DIV;
            chk("valid", 32'(valid), 32'(ev));
            chk("changed", 32'(changed), 32'(ec));
            chk("joy", 32'(joy), 32'(jexp));
            chk("joyLd", 32'(joyLd), 32'(exp_ld));
            chk("joyCk", 32'(joyCk), 32'(exp_ck));
            chk("joyS", 32'(joyS), 32'd1);
            if (!joyLd) begin
                lat = pat;
                idx = 0;
            end else if (pck && !joyCk) begin
                idx++;
            end
            pck = joyCk;
            joyQ = (idx < 16) ? lat[idx] : 1'b1;
        end
    end

    // Adaptor model for the three-port, six-bit instance.
    initial begin
        int idx3;
        bit pk3;
        logic [17:0] lat3;
        idx3 = 0; pk3 = 1'b0; lat3 = '1;
        forever begin
            @(negedge clock);
            if (!joyLd3) begin
                lat3 = PAT3;
                idx3 = 0;
            end else if (pk3 && !joyCk3) begin
                idx3++;
            end
            pk3 = joyCk3;
            joyQ3 = (idx3 < 18) ? lat3[idx3] : 1'b1;
        end
    end

    // Three-port, six-bit instance: latency, 38-tick frame, port-2 up.
    initial begin
        int c;
        @(negedge reset);
        c = 0;
        do begin @(negedge clock); c++; end while (!valid3 && c < 400);
        chk("p3_first_valid", 32'(c), 32'd156);
        c = 0;
        do begin @(negedge clock); c++; end while (!valid3 && c < 400);
        chk("p3_frame_clocks", 32'(c), 32'd152);
        chk("p3_joy", 32'(joy3), 32'h080000);
        chk("p3_joy_23_22", 32'(joy3[23:22]), 32'd0);
    end

    task automatic wait_valid(input int bound, output int cyc);
        bit pk;
        cyc = 0; nld = 0; nrise = 0; pk = joyCk;
        do begin
            @(negedge clock);
            cyc++;
            if (!joyLd && !valid) nld++;
            if (joyCk && !pk) nrise++;
            pk = joyCk;
        end while (!valid && cyc < bound);
        if (!valid) chk("valid_timeout", 32'(valid), 32'd1);
    endtask

    logic [15:0] PATS [6];
    logic [15:0] LJ [6];
    logic        LC [6];

    initial begin
        int cyc, n, nv, nck, nldi;
        PATS = '{16'hFFF6, 16'hFFF6, 16'h7EEF, 16'hFFF6, 16'hFFEF, 16'hFFEF};
`ifdef JOYSTICK_DEBOUNCE_EN
        LJ = '{16'h0000, 16'h0009, 16'h0009, 16'h0009, 16'h0009, 16'h0010};
        LC = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        LJ = '{16'h0009, 16'h0009, 16'h8810, 16'h0009, 16'h0010, 16'h0010};
        LC = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        enable = 1'b1;
        pat = PATS[0];
        repeat (3) @(negedge clock);
        chk("reset_joy", 32'(joy), 32'd0);
        chk("reset_joyLd", 32'(joyLd), 32'd1);
        #1 reset = 1'b0;

        for (int f = 0; f < 6; f++) begin
            if (f > 0) #1 pat = PATS[f];
            wait_valid(4000, cyc);
            if (f == 0) begin
                chk("first_valid_clocks", 32'(cyc), 32'd1750);
                chk("ld_low_clocks", 32'(nld), 32'd50);
                chk("ck_rises_frame", 32'(nrise), 32'd16);
            end else begin
                chk("frame_clocks", 32'(cyc), 32'd1700);
            end
            chk("frame_joy", 32'(joy), 32'(LJ[f]));
            chk("frame_changed", 32'(changed), 32'(LC[f]));
        end

        // Drop enable mid-SHIFT: frame completes, then the bus parks.
        repeat (500) @(negedge clock);
        #1 enable = 1'b0;
        wait_valid(2000, cyc);
        chk("drop_valid_clocks", 32'(cyc), 32'd1200);
        nv = 0; nck = 0; nldi = 0;
        repeat (1000) begin
            @(negedge clock);
            if (valid) nv++;
            if (joyCk) nck++;
            if (!joyLd) nldi++;
        end
        chk("idle_valids", 32'(nv), 32'd0);
        chk("idle_ck_high", 32'(nck), 32'd0);
        chk("idle_ld_low", 32'(nldi), 32'd0);
        #1 enable = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (joyLd && n < 200);
        chk("reenable_load_clocks", 32'(n), 32'd50);
        wait_valid(2000, cyc);
        chk("reenable_frame_clocks", 32'(cyc), 32'd1700);
        chk("reenable_joy", 32'(joy), 32'h0010);

        // Reset mid-SHIFT with fire held.
        repeat (600) @(negedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("midreset_joy", 32'(joy), 32'd0);
        chk("midreset_valid", 32'(valid), 32'd0);
        #1 reset = 1'b0;
        wait_valid(4000, cyc);
        chk("after_reset_clocks", 32'(cyc), 32'd1750);
`ifdef JOYSTICK_DEBOUNCE_EN
        chk("after_reset_joy", 32'(joy), 32'h0000);
`else
        chk("after_reset_joy", 32'(joy), 32'h0010);
`endif
        wait_valid(2000, cyc);
        chk("after_reset_joy2", 32'(joy), 32'h0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
